// File: rtl/param_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_frame_bank                                                           |
// | Assembles sync/payload/checksum frames into a shadow bank and publishes it |
// | atomically on a checksum match.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module param_frame_bank #(
  parameter int                DATA_W    = 16,
  parameter int                NUM_WORDS = 6,
  parameter logic [DATA_W-1:0] SYNC_WORD = 16'hA55A,
  parameter int                TIMEOUT   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          pi_flag,
  output logic [NUM_WORDS*DATA_W-1:0]   params,
  output logic                          frame_valid,
  output logic                          frame_err,
  output logic [$clog2(NUM_WORDS+1)-1:0] idx,
  output logic [7:0]                    frame_cnt
);

  localparam int IDX_W = $clog2(NUM_WORDS+1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT-1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_WORDS-1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [IDX_W-1:0]              r_idx;
  logic [DATA_W-1:0]             r_acc;
  logic [TMR_W-1:0]              r_timer;
  logic [NUM_WORDS*DATA_W-1:0]   r_shadow;
  logic [NUM_WORDS*DATA_W-1:0]   r_params;
  logic                          r_frame_valid;
  logic                          r_frame_err;
  logic [7:0]                    r_frame_cnt;
  logic                          w_good;
  logic                          w_bad;
  logic                          w_expire;
  logic                          w_last;
  logic                          w_tmr_done;

  assign w_last     = (r_idx == c_idx_last);
  assign w_tmr_done = (r_timer == c_tmr_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else if (!en) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A strobe in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (pi_flag && (data_in == SYNC_WORD)) begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pi_flag) begin
          if (w_last) begin
            w_state_nxt = ST_CHECK;
          end
        end else if (w_tmr_done) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (pi_flag) begin
          w_state_nxt = ST_HUNT;
          if (data_in == r_acc) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end else if (w_tmr_done) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_acc         <= '0;
      r_timer       <= '0;
      r_shadow      <= '0;
      r_params      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else if (!en) begin
      r_idx         <= '0;
      r_acc         <= '0;
      r_timer       <= '0;
      r_params      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_good;
      r_frame_err   <= w_bad | w_expire;
      if (w_good) begin
        r_params    <= r_shadow;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      case (r_state)
        ST_PAYLOAD: begin
          if (pi_flag) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_shadow[k*DATA_W +: DATA_W] <= data_in;
              end
            end
            r_acc   <= r_acc + data_in;
            r_timer <= '0;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
          end else if (w_expire) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CHECK: begin
          if (pi_flag || w_expire) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_idx   <= '0;
          r_acc   <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign params      = r_params;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign idx         = r_idx;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_param_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_param_frame_bank                                                        |
// | Directed vector table plus hand sequences for timeout/reset/back-to-back.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_param_frame_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data_in;
  logic        pi_flag;
  logic [95:0] params;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  idx;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  param_frame_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_in     (data_in),
    .pi_flag     (pi_flag),
    .params      (params),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .idx         (idx),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          e;
    bit          p;
    logic [15:0] d;
    logic        fv;
    logic        fe;
    logic [7:0]  cnt;
    logic [2:0]  ix;
    logic [95:0] prm;
  } vec_t;

  vec_t vq[$];

  function automatic logic [95:0] pk(input logic [15:0] w0, w1, w2, w3, w4, w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  function automatic void add(input bit e, input bit p, input logic [15:0] d,
                              input logic fv, input logic fe, input logic [7:0] cnt,
                              input logic [2:0] ix, input logic [95:0] prm);
    vec_t v;
    v.e = e; v.p = p; v.d = d; v.fv = fv; v.fe = fe; v.cnt = cnt; v.ix = ix; v.prm = prm;
    vq.push_back(v);
  endfunction

  task automatic step(input bit e, input bit p, input logic [15:0] d);
    en = e; pi_flag = p; data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic fv, input logic fe,
                       input logic [7:0] cnt, input logic [2:0] ix, input logic [95:0] prm);
    checks++;
    if (frame_valid !== fv || frame_err !== fe || frame_cnt !== cnt ||
        idx !== ix || params !== prm) begin
      errors++;
      $display("FAIL %s: got fv=%b fe=%b cnt=%0d idx=%0d params=%h, want fv=%b fe=%b cnt=%0d idx=%0d params=%h",
               name, frame_valid, frame_err, frame_cnt, idx, params, fv, fe, cnt, ix, prm);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1 && frame_err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL exclusive: frame_valid and frame_err both 1");
    end
  end

  localparam logic [95:0] P0 = 96'd0;

  initial begin
    logic [95:0] p1, p2, p3, p4;
    p1 = pk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    p2 = pk(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    p3 = pk(16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    p4 = pk(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12);

    // Good frame
    add(1, 1, 16'hA55A, 0, 0, 0, 3'd0, P0);
    for (int k = 1; k <= 6; k++) add(1, 1, 16'(k), 0, 0, 0, 3'(k % 6), P0);
    add(1, 1, 16'h0015, 1, 0, 1, 3'd0, p1);
    // Bad checksum, arriving back-to-back
    add(1, 1, 16'hA55A, 0, 0, 1, 3'd0, p1);
    for (int k = 1; k <= 6; k++) add(1, 1, 16'(k), 0, 0, 1, 3'(k % 6), p1);
    add(1, 1, 16'h0016, 0, 1, 1, 3'd0, p1);
    // Garbage in hunt
    add(1, 1, 16'h1234, 0, 0, 1, 3'd0, p1);
    add(1, 1, 16'hFFFF, 0, 0, 1, 3'd0, p1);
    add(1, 0, 16'h0000, 0, 0, 1, 3'd0, p1);
    // Sync value as payload data; sum A55A+15 = A569
    add(1, 1, 16'hA55A, 0, 0, 1, 3'd0, p1);
    add(1, 1, 16'hA55A, 0, 0, 1, 3'd1, p1);
    for (int k = 1; k <= 5; k++) add(1, 1, 16'(k), 0, 0, 1, 3'((k + 1) % 6), p1);
    add(1, 1, 16'hA569, 1, 0, 2, 3'd0, p2);
    // Checksum wraps modulo 2^16
    add(1, 1, 16'hA55A, 0, 0, 2, 3'd0, p2);
    add(1, 1, 16'hFFFF, 0, 0, 2, 3'd1, p2);
    add(1, 1, 16'h0001, 0, 0, 2, 3'd2, p2);
    for (int k = 3; k <= 6; k++) add(1, 1, 16'h0000, 0, 0, 2, 3'(k % 6), p2);
    add(1, 1, 16'h0000, 1, 0, 3, 3'd0, p3);
    add(1, 0, 16'h0000, 0, 0, 3, 3'd0, p3);
    // en drop mid-frame clears params, keeps count; then a full frame (sum 7..12 = 0x39)
    add(1, 1, 16'hA55A, 0, 0, 3, 3'd0, p3);
    for (int k = 7; k <= 9; k++) add(1, 1, 16'(k), 0, 0, 3, 3'(k - 6), p3);
    add(0, 0, 16'h0000, 0, 0, 3, 3'd0, P0);
    add(1, 1, 16'hA55A, 0, 0, 3, 3'd0, P0);
    for (int k = 7; k <= 12; k++) add(1, 1, 16'(k), 0, 0, 3, 3'((k - 6) % 6), P0);
    add(1, 1, 16'h0039, 1, 0, 4, 3'd0, p4);

    rst_n = 1'b0; en = 1'b0; pi_flag = 1'b0; data_in = 16'h0;
    @(posedge clk);
    @(negedge clk);
    check("reset", 0, 0, 8'd0, 3'd0, P0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].e, vq[i].p, vq[i].d);
      check($sformatf("vec%0d", i), vq[i].fv, vq[i].fe, vq[i].cnt, vq[i].ix, vq[i].prm);
    end

    // Timeout in PAYLOAD: error on the 1000th idle cycle, partial data never published
    step(1, 1, 16'hA55A);
    step(1, 1, 16'd1);
    step(1, 1, 16'd2);
    for (int k = 0; k < 999; k++) step(1, 0, 16'h0);
    check("to_before", 0, 0, 8'd4, 3'd2, p4);
    step(1, 0, 16'h0);
    check("to_expire", 0, 1, 8'd4, 3'd0, p4);
    step(1, 0, 16'h0);
    check("to_after", 0, 0, 8'd4, 3'd0, p4);
    step(1, 1, 16'd1);
    check("to_hunt", 0, 0, 8'd4, 3'd0, p4);

    // Strobe in the expiry cycle is accepted
    step(1, 1, 16'hA55A);
    step(1, 1, 16'd1);
    for (int k = 0; k < 999; k++) step(1, 0, 16'h0);
    step(1, 1, 16'd2);
    check("to_strobe_wins", 0, 0, 8'd4, 3'd2, p4);
    for (int k = 3; k <= 6; k++) step(1, 1, 16'(k));
    step(1, 1, 16'h0015);
    check("to_recover", 1, 0, 8'd5, 3'd0, p1);

    // Async reset while in CHECK
    step(1, 1, 16'hA55A);
    for (int k = 1; k <= 6; k++) step(1, 1, 16'(k));
    pi_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, 0, 8'd0, 3'd0, P0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two frames at one strobe per cycle
    for (int f = 1; f <= 2; f++) begin
      step(1, 1, 16'hA55A);
      for (int k = 1; k <= 6; k++) step(1, 1, 16'(k));
      step(1, 1, 16'h0015);
      check($sformatf("b2b_frame%0d", f), 1, 0, 8'(f), 3'd0, p1);
    end
    step(1, 0, 16'h0);
    check("b2b_idle", 0, 0, 8'd2, 3'd0, p1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
